adder_share_arbiter: RTL

Controller that time-shares one 64-bit fast adder (`fast_adder_ques1`-class, registered output) between two independent requesters. Each requester submits operands over a valid/ready handshake and gets back sum and carry over a separate valid/ready response channel. The block sequences the adder: it launches operands, waits the adder's fixed latency, captures the result and routes it to the granted requester. It sits between client logic and the shared adder instance, which is connected externally via the `add_*` ports.

---
 rtl/adder_share_arbiter_if.sv | 47 ++++
 rtl/adder_share_arbiter.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/adder_share_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : adder_share_arbiter_if
// Purpose  : Bundles the two requester channels, the two response channels
//            and the shared-adder connection of adder_share_arbiter.
//            slave  = the arbiter side, master = clients plus adder side.
// Revision : 1.0 - initial release
// ============================================================================
interface adder_share_arbiter_if #(
  parameter int WIDTH = 64
);
  logic             req0_valid;
  logic             req1_valid;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic             req0_ready;
  logic             req1_ready;
  logic             rsp0_valid;
  logic             rsp1_valid;
  logic [WIDTH-1:0] rsp0_sum;
  logic [WIDTH-1:0] rsp1_sum;
  logic             rsp0_carry;
  logic             rsp1_carry;
  logic             rsp0_ready;
  logic             rsp1_ready;
  logic [WIDTH-1:0] add_a;
  logic [WIDTH-1:0] add_b;
  logic [WIDTH-1:0] add_sum;
  logic             add_carry;

  modport slave (
    input  req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
    input  rsp0_ready, rsp1_ready, add_sum, add_carry,
    output req0_ready, req1_ready, rsp0_valid, rsp1_valid,
    output rsp0_sum, rsp1_sum, rsp0_carry, rsp1_carry, add_a, add_b
  );

  modport master (
    output req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
    output rsp0_ready, rsp1_ready, add_sum, add_carry,
    input  req0_ready, req1_ready, rsp0_valid, rsp1_valid,
    input  rsp0_sum, rsp1_sum, rsp0_carry, rsp1_carry, add_a, add_b
  );
endinterface
`default_nettype wire

// File: rtl/adder_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : adder_share_arbiter
// Purpose  : Time-shares one registered-output adder between two requesters.
//            Launches the winner's operands, waits ADDER_LAT edges, captures
//            {carry,sum} and returns it on the winner's response channel.
//            Optional feature macro: ADD_ARB_ROUND_ROBIN_EN (round-robin
//            arbitration; fixed priority to req0 when undefined).
// Revision : 1.0 - initial release
// ============================================================================
module adder_share_arbiter #(
  parameter int WIDTH     = 64,
  parameter int ADDER_LAT = 1   // legal 1..7
) (
  input  logic                 clk,
  input  logic                 rst,
  adder_share_arbiter_if.slave bus,
  output logic                 busy,
  output logic                 grant_id
);

  localparam logic [2:0] C_LAT = 3'(ADDER_LAT);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t           r_state;
  logic [2:0]       r_cnt;
  logic [WIDTH-1:0] r_add_a;
  logic [WIDTH-1:0] r_add_b;
  logic [WIDTH-1:0] r_rsp0_sum;
  logic [WIDTH-1:0] r_rsp1_sum;
  logic             r_rsp0_carry;
  logic             r_rsp1_carry;
  logic             r_rsp0_valid;
  logic             r_rsp1_valid;
  logic             r_grant;

  logic w_win;      // 0 = req0, 1 = req1; meaningful only when some req is valid
  logic w_idle;
  logic w_accept;
  logic w_rsp_hs;

`ifdef ADD_ARB_ROUND_ROBIN_EN
  logic r_last;     // requester granted most recently

  // Under contention favour the requester that was not granted last
  always_comb begin
    w_win = bus.req1_valid & ~bus.req0_valid;
    if (bus.req0_valid && bus.req1_valid) begin
      w_win = ~r_last;
    end
  end

  // Pointer follows every accepted grant; reset makes req0 win first
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last <= 1'b1;
    end else if (w_accept) begin
      r_last <= w_win;
    end
  end
`else
  assign w_win = bus.req1_valid & ~bus.req0_valid;
`endif

  // Requests are only taken in IDLE and never while reset is asserted
  assign w_idle         = (r_state == S_IDLE) & ~rst;
  assign bus.req0_ready = w_idle & bus.req0_valid & ~w_win;
  assign bus.req1_ready = w_idle & bus.req1_valid &  w_win;
  assign w_accept       = w_idle & (bus.req0_valid | bus.req1_valid);
  assign w_rsp_hs       = r_grant ? (r_rsp1_valid & bus.rsp1_ready)
                                  : (r_rsp0_valid & bus.rsp0_ready);

  assign bus.add_a      = r_add_a;
  assign bus.add_b      = r_add_b;
  assign bus.rsp0_valid = r_rsp0_valid;
  assign bus.rsp1_valid = r_rsp1_valid;
  assign bus.rsp0_sum   = r_rsp0_sum;
  assign bus.rsp1_sum   = r_rsp1_sum;
  assign bus.rsp0_carry = r_rsp0_carry;
  assign bus.rsp1_carry = r_rsp1_carry;
  assign busy           = (r_state != S_IDLE);
  assign grant_id       = r_grant;

  // Sequencer: launch operands, count out the adder latency, hold the result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= 3'd0;
      r_add_a      <= '0;
      r_add_b      <= '0;
      r_rsp0_sum   <= '0;
      r_rsp1_sum   <= '0;
      r_rsp0_carry <= 1'b0;
      r_rsp1_carry <= 1'b0;
      r_rsp0_valid <= 1'b0;
      r_rsp1_valid <= 1'b0;
      r_grant      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_add_a <= w_win ? bus.req1_a : bus.req0_a;
            r_add_b <= w_win ? bus.req1_b : bus.req0_b;
            r_grant <= w_win;
            r_cnt   <= C_LAT;
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (r_cnt != 3'd0) begin
            r_cnt <= r_cnt - 3'd1;
          end else begin
            if (r_grant) begin
              r_rsp1_sum   <= bus.add_sum;
              r_rsp1_carry <= bus.add_carry;
              r_rsp1_valid <= 1'b1;
            end else begin
              r_rsp0_sum   <= bus.add_sum;
              r_rsp0_carry <= bus.add_carry;
              r_rsp0_valid <= 1'b1;
            end
            r_state <= S_RESP;
          end
        end
        S_RESP: begin
          if (w_rsp_hs) begin
            r_rsp0_valid <= 1'b0;
            r_rsp1_valid <= 1'b0;
            r_state      <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
